echo_tester: RTL and testbench
==============================

Name: echo_tester

Overview:
- Initiator side of the UART byte-echo protocol.
- Transmits a deterministic byte sequence ending in the 0x55 terminator, waits for each byte to be echoed back, compares it, and reports pass/fail and an error count.
- Sits beside the other command blocks on the shared UART tx/rx strobes, uses the same activate/done handshake, and is used for link bring-up and self-test against the echoing responder.

Parameters:
- LEN, 8, number of payload bytes before the terminator (1..255).
- SEED, 8'h10, first payload byte value.
- TIMEOUT, 100000, clk cycles allowed from tx_start to echo arrival.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- activate  in  1  start request; level, held by controller until done observed
- done  out  1  sequence finished; held until activate drops
- pass  out  1  valid while done; 1 when err_count==0
- err_count  out  8  saturating mismatch+timeout count for the current run
- tx_done  in  1  one-cycle pulse, UART transmitter finished a byte
- tx_active  in  1  UART transmitter busy
- rx_ready  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_data  out  8  byte to transmit; stable from START until tx_done
- tx_start  out  1  one-cycle transmit request

Behaviour:
- Reset (async, reset==0): state IDLE; done=0, pass=0, err_count=0, tx_start=0, tx_data=0, idx=0, timer=0. A reset mid-run aborts immediately. No byte is resumed.
- Byte generation:
  - payload byte k (0..LEN-1) = (SEED+k) mod 256.
  - A payload byte equal to 8'h55 is replaced by 8'hAA, so no early terminator is ever sent.
  - Byte LEN is the terminator 8'h55.
- States:
  - IDLE: tx_start=0. On activate=1: clear err_count, pass, idx, then go to WAIT_IDLE.
  - WAIT_IDLE: go to START when tx_active==0.
  - START: drive tx_data=byte(idx), tx_start=1 for exactly this cycle, clear timer and echo flag, then go to WAIT_TX.
  - WAIT_TX: wait for tx_done, then go to WAIT_ECHO. An rx_ready seen here is captured (echo flag set, byte latched).
  - WAIT_ECHO:
    - Timer increments every cycle from START onward.
    - When the echo flag is set, or rx_ready arrives: compare the latched byte with tx_data. On mismatch, err_count += 1. Go to NEXT.
    - If timer reaches TIMEOUT with no echo: err_count += 1, go to NEXT.
    - rx_ready and timeout in the same cycle: the echo wins; no timeout error is counted.
  - NEXT: if idx==LEN (terminator was just sent), go to DONE. Otherwise idx += 1 and go to WAIT_IDLE.
  - DONE: done=1, pass=(err_count==0). Go to IDLE when activate==0 && tx_active==0 && rx_ready==0. done and pass clear on that IDLE entry.
- Counters and widths:
  - err_count saturates at 8'hFF and never wraps.
  - idx is 8 bits.
  - timer is $clog2(TIMEOUT+1) bits and never wraps past TIMEOUT.
- Stray inputs:
  - rx_ready in IDLE, WAIT_IDLE, START, NEXT or DONE is ignored.
  - A second rx_ready within one byte slot is ignored; only the first is compared.
  - activate dropping mid-run does not abort; the run completes, and DONE then exits on the next cycle.
- Latency: START sits one cycle after tx_active is seen low; the compare result is registered one cycle after rx_ready.

Decomposition:
- Shared uart_pkg: state enum type, ECHO_TERM=8'h55, ECHO_SUBST=8'hAA. The echoing responder uses the same ECHO_TERM.
- One natural sub-module: echo_timeout_timer (clear, enable, expired), parameterised by TIMEOUT, reusable by other command blocks.
- The byte generator and compare stay inline.

Test Plan:
- LEN=4, SEED=8'h10, ideal loopback (echo 20 cycles after tx_done) -> tx bytes 10,11,12,13,55 with one tx_start pulse each; done=1, pass=1, err_count=0.
- LEN=4, SEED=8'h53 -> transmitted bytes 53,54,AA,56,55; loopback echoes the sent bytes; pass=1.
- LEN=4, SEED=8'h10, echo of the third byte corrupted to 8'h00 -> err_count=1, pass=0, all 5 bytes still sent.
- TIMEOUT=50, echo of the second byte dropped -> the next tx_start follows ~51 cycles after that START; final err_count=1, pass=0.
- Hold activate=1 after done -> done stays 1 for 100 cycles and no tx_start occurs; drop activate -> IDLE next cycle, done=0. Re-assert -> err_count cleared and the sequence restarts from SEED.
- Assert reset=0 asynchronously during WAIT_ECHO of the second byte -> outputs 0 within the same cycle and no further tx_start. After release plus activate, the first byte sent is SEED.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART command-block definitions: echo FSM states, terminator bytes and small helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StStart,
        StWaitTx,
        StWaitEcho,
        StNext,
        StDone
    } echo_state_e;

    localparam logic [7:0] ECHO_TERM  = 8'h55;
    localparam logic [7:0] ECHO_SUBST = 8'hAA;

    // Byte idx of a run: seed+idx, never an early terminator; index `last` is the terminator.
    function automatic logic [7:0] gen_byte(input logic [7:0] seed, input logic [7:0] idx,
                                            input logic [7:0] last);
        logic [7:0] b;
        b = seed + idx;
        if (idx == last) begin
            return ECHO_TERM;
        end
        return (b == ECHO_TERM) ? ECHO_SUBST : b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/echo_timeout_timer.sv
// Cycle timer that counts while enabled and sticks at TIMEOUT, raising expired there.
module echo_timeout_timer #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != LIMIT) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/echo_tester.sv
// Initiator of the UART byte-echo self-test: sends a seeded byte run plus terminator,
// compares every echo and reports pass/fail with a saturating error count.
module echo_tester #(
    parameter int unsigned LEN     = 8,
    parameter logic [7:0]  SEED    = 8'h10,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    input  logic       tx_done,
    input  logic       tx_active,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_start
);
    import uart_pkg::*;

    localparam logic [7:0] LAST = 8'(LEN);

    echo_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  txd_q, txd_d;
    logic        echo_flag_q, echo_flag_d;
    logic [7:0]  echo_byte_q, echo_byte_d;
    logic        timer_clear, timer_en, expired;

    echo_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        txd_d       = txd_q;
        echo_flag_d = echo_flag_q;
        echo_byte_d = echo_byte_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (activate) begin
                    err_d   = 8'd0;
                    idx_d   = 8'd0;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                // Load the byte here so tx_data is already valid in the START cycle.
                if (!tx_active) begin
                    txd_d   = gen_byte(SEED, idx_q, LAST);
                    state_d = StStart;
                end
            end
            StStart: begin
                timer_clear = 1'b1;
                echo_flag_d = 1'b0;
                state_d     = StWaitTx;
            end
            StWaitTx: begin
                timer_en = 1'b1;
                if (rx_ready && !echo_flag_q) begin
                    echo_flag_d = 1'b1;
                    echo_byte_d = rx_data;
                end
                if (tx_done) begin
                    state_d = StWaitEcho;
                end
            end
            StWaitEcho: begin
                timer_en = 1'b1;
                // An echo beats a simultaneous timeout.
                if (echo_flag_q || rx_ready) begin
                    if ((echo_flag_q ? echo_byte_q : rx_data) != txd_q) begin
                        err_d = sat_inc(err_q);
                    end
                    state_d = StNext;
                end else if (expired) begin
                    err_d   = sat_inc(err_q);
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == LAST) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StWaitIdle;
                end
            end
            StDone: begin
                if (!activate && !tx_active && !rx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= 8'd0;
            err_q       <= 8'd0;
            txd_q       <= 8'd0;
            echo_flag_q <= 1'b0;
            echo_byte_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            txd_q       <= txd_d;
            echo_flag_q <= echo_flag_d;
            echo_byte_q <= echo_byte_d;
        end
    end

    assign tx_start  = (state_q == StStart);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 8'd0);
    assign err_count = err_q;
    assign tx_data   = txd_q;

endmodule

// File: tb/tb_echo_tester.sv
// Bench for echo_tester: two instances (different SEED) with a loopback responder each.
module tb_echo_tester;

    localparam int unsigned LEN = 4;
    localparam int unsigned TMO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       activate [2];
    logic       done [2];
    logic       pass [2];
    logic [7:0] err_count [2];
    logic       tx_done [2];
    logic       tx_active [2];
    logic       rx_ready [2];
    logic [7:0] rx_data [2];
    logic [7:0] tx_data [2];
    logic       tx_start [2];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q [2][$];
    int         drop_slot [2];
    int         corrupt_slot [2];
    int         nstart [2];
    int         start_t [2][16];

    typedef struct {
        int idx;
        int corrupt;
        int drop;
        int exp_err;
        int exp_pass;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    echo_tester #(.LEN(LEN), .SEED(8'h10), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(reset), .activate(activate[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err_count[0]), .tx_done(tx_done[0]), .tx_active(tx_active[0]),
        .rx_ready(rx_ready[0]), .rx_data(rx_data[0]), .tx_data(tx_data[0]),
        .tx_start(tx_start[0])
    );

    echo_tester #(.LEN(LEN), .SEED(8'h53), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .reset(reset), .activate(activate[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err_count[1]), .tx_done(tx_done[1]), .tx_active(tx_active[1]),
        .rx_ready(rx_ready[1]), .rx_data(rx_data[1]), .tx_data(tx_data[1]),
        .tx_start(tx_start[1])
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] seed_of(input int idx);
        return (idx == 0) ? 8'h10 : 8'h53;
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] seed, input int k);
        logic [7:0] b;
        if (k == int'(LEN)) return 8'h55;
        b = seed + 8'(k);
        return (b == 8'h55) ? 8'hAA : b;
    endfunction

    task automatic push_run(input int idx);
        nstart[idx] = 0;
        for (int k = 0; k <= int'(LEN); k++) exp_q[idx].push_back(model_byte(seed_of(idx), k));
    endtask

    task automatic wait_done(input int idx, input int limit);
        int n;
        n = 0;
        while (done[idx] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", int'(done[idx] === 1'b1), 1);
    endtask

    // Loopback: 10-cycle transmit, echo 20 cycles after tx_done, optional drop/corruption.
    task automatic responder(input int idx);
        logic [7:0] b;
        int         slot;
        forever begin
            @(negedge clk);
            if (tx_start[idx] === 1'b1) begin
                b    = tx_data[idx];
                slot = nstart[idx];
                if (slot < 16) start_t[idx][slot] = cyc;
                nstart[idx]++;
                if (exp_q[idx].size() == 0) check("unexpected_tx_start", int'(b), -1);
                else check("tx_byte", int'(b), int'(exp_q[idx].pop_front()));
                tx_active[idx] = 1'b1;
                @(negedge clk);
                check("tx_start_one_cycle", int'(tx_start[idx]), 0);
                repeat (9) @(negedge clk);
                check("tx_data_stable", int'(tx_data[idx]), int'(b));
                tx_active[idx] = 1'b0;
                tx_done[idx]   = 1'b1;
                @(negedge clk);
                tx_done[idx] = 1'b0;
                repeat (19) @(negedge clk);
                if (slot != drop_slot[idx]) begin
                    rx_ready[idx] = 1'b1;
                    rx_data[idx]  = (slot == corrupt_slot[idx]) ? 8'h00 : b;
                    @(negedge clk);
                    rx_ready[idx] = 1'b0;
                end
            end
        end
    endtask

    initial responder(0);
    initial responder(1);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap;
        bit  hold_bad;
        int  starts_before;
        for (int i = 0; i < 2; i++) begin
            activate[i] = 1'b0; tx_done[i] = 1'b0; tx_active[i] = 1'b0;
            rx_ready[i] = 1'b0; rx_data[i] = 8'h00;
            drop_slot[i] = -1; corrupt_slot[i] = -1; nstart[i] = 0;
        end
        vecs[0] = '{idx: 0, corrupt: -1, drop: -1, exp_err: 0, exp_pass: 1};
        vecs[1] = '{idx: 1, corrupt: -1, drop: -1, exp_err: 0, exp_pass: 1};
        vecs[2] = '{idx: 0, corrupt: 2,  drop: -1, exp_err: 1, exp_pass: 0};
        vecs[3] = '{idx: 0, corrupt: -1, drop: 1,  exp_err: 1, exp_pass: 0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_done", int'(done[i]), 0);
            check("reset_pass", int'(pass[i]), 0);
            check("reset_err", int'(err_count[i]), 0);
            check("reset_tx_start", int'(tx_start[i]), 0);
            check("reset_tx_data", int'(tx_data[i]), 0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            int d;
            d = vecs[v].idx;
            corrupt_slot[d] = vecs[v].corrupt;
            drop_slot[d]    = vecs[v].drop;
            push_run(d);
            activate[d] = 1'b1;
            repeat (2) @(negedge clk);
            check("err_cleared_on_start", int'(err_count[d]), 0);
            wait_done(d, 2000);
            check("final_err_count", int'(err_count[d]), vecs[v].exp_err);
            check("final_pass", int'(pass[d]), vecs[v].exp_pass);
            check("tx_start_count", nstart[d], int'(LEN) + 1);
            check("scoreboard_empty", exp_q[d].size(), 0);
            if (vecs[v].drop >= 0) begin
                gap = start_t[d][vecs[v].drop + 1] - start_t[d][vecs[v].drop];
                check("timeout_gap_in_range", int'(gap >= 50 && gap <= 60), 1);
            end
            if (v == 2) begin
                hold_bad = 1'b0;
                starts_before = nstart[d];
                repeat (100) begin
                    @(negedge clk);
                    if (done[d] !== 1'b1) hold_bad = 1'b1;
                end
                check("done_held_with_activate", int'(hold_bad), 0);
                check("no_tx_start_while_held", nstart[d], starts_before);
            end
            activate[d] = 1'b0;
            @(negedge clk);
            check("done_clear_after_drop", int'(done[d]), 0);
            check("pass_clear_after_drop", int'(pass[d]), 0);
            repeat (5) @(negedge clk);
            drop_slot[d] = -1;
            corrupt_slot[d] = -1;
        end

        // Asynchronous reset during WAIT_ECHO of the second byte.
        push_run(0);
        activate[0] = 1'b1;
        begin
            int n;
            n = 0;
            while (nstart[0] < 2 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("second_start_seen", int'(nstart[0] >= 2), 1);
        end
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_done", int'(done[0]), 0);
        check("async_reset_err", int'(err_count[0]), 0);
        check("async_reset_tx_start", int'(tx_start[0]), 0);
        check("async_reset_tx_data", int'(tx_data[0]), 0);
        activate[0] = 1'b0;
        starts_before = nstart[0];
        repeat (60) @(negedge clk);
        check("no_start_in_reset", nstart[0], starts_before);
        exp_q[0].delete();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        push_run(0);
        activate[0] = 1'b1;
        wait_done(0, 2000);
        check("post_reset_err", int'(err_count[0]), 0);
        check("post_reset_pass", int'(pass[0]), 1);
        check("post_reset_starts", nstart[0], int'(LEN) + 1);
        activate[0] = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
